// File: rtl/deadlock_origin_arbiter_pkg.sv
// Shared types and sizing helpers for the deadlock origin arbiter.
// Holds the FSM state encoding, the report index width function and the dl_count width.
package deadlock_origin_arbiter_pkg;

  localparam int DL_COUNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CONFIRM = 3'd1,
    ST_LOCKED  = 3'd2,
    ST_CLEAR   = 3'd3,
    ST_DRAIN   = 3'd4
  } arb_state_e;

  function automatic int idx_w(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      return 1;
    end else begin
      return w;
    end
  endfunction

endpackage

// File: rtl/deadlock_origin_arbiter_prio.sv
// Lowest-set-bit priority picker: one-hot of the lowest asserted flag plus its binary index.
// Purely combinational; the top registers whatever it uses.
module dl_prio_onehot
  import deadlock_origin_arbiter_pkg::*;
#(
  parameter int PROC_NUM = 2
) (
  input  logic [PROC_NUM-1:0]           vec,
  output logic [PROC_NUM-1:0]           onehot,
  output logic [idx_w(PROC_NUM)-1:0]    idx
);

  localparam int IDX_W = idx_w(PROC_NUM);

  logic [IDX_W-1:0] idx_s;

  // Two's-complement trick isolates the lowest set bit.
  assign onehot = vec & (~vec + PROC_NUM'(1));

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx_s = '0;
    for (int i = PROC_NUM - 1; i >= 0; i--) begin
      idx_s = vec[i] ? IDX_W'(i) : idx_s;
    end
  end

  assign idx = idx_s;

endmodule

// File: rtl/deadlock_origin_arbiter.sv
// Elects one deadlock origin among PROC_NUM suspect flags, confirms it over CONFIRM_CYCLES
// edges, then locks, pulses a token clear and waits for all flags to drop before re-arming.
module deadlock_origin_arbiter
  import deadlock_origin_arbiter_pkg::*;
#(
  parameter int PROC_NUM       = 2,
  parameter int CONFIRM_CYCLES = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [PROC_NUM-1:0]         dl_in_vec,
  output logic                        dl_detect_out,
  output logic [PROC_NUM-1:0]         origin,
  output logic                        token_clear,
  output logic                        report_vld,
  output logic [idx_w(PROC_NUM)-1:0]  report_idx,
  output logic [DL_COUNT_W-1:0]       dl_count
);

  localparam int               IDX_W    = idx_w(PROC_NUM);
  localparam logic [7:0]       CONF_MAX = 8'(CONFIRM_CYCLES);
  localparam logic [DL_COUNT_W-1:0] CNT_SAT = 8'd255;

  arb_state_e                state_r, state_nxt_s;
  logic [PROC_NUM-1:0]       cand_r, cand_nxt_s;
  logic [IDX_W-1:0]          cand_idx_r, cand_idx_nxt_s;
  logic [7:0]                conf_cnt_r, conf_cnt_nxt_s;
  logic                      det_r, det_nxt_s;
  logic [PROC_NUM-1:0]       origin_r, origin_nxt_s;
  logic                      tc_r, tc_nxt_s;
  logic                      rv_r, rv_nxt_s;
  logic [IDX_W-1:0]          ridx_r, ridx_nxt_s;
  logic [DL_COUNT_W-1:0]     dl_cnt_r, dl_cnt_nxt_s;

  logic [PROC_NUM-1:0]       pick_onehot_s;
  logic [IDX_W-1:0]          pick_idx_s;

  dl_prio_onehot #(
    .PROC_NUM (PROC_NUM)
  ) u_prio (
    .vec    (dl_in_vec),
    .onehot (pick_onehot_s),
    .idx    (pick_idx_s)
  );

  // Next-state and next-output logic; pulses default low, everything else holds.
  always_comb begin
    state_nxt_s    = state_r;
    cand_nxt_s     = cand_r;
    cand_idx_nxt_s = cand_idx_r;
    conf_cnt_nxt_s = conf_cnt_r;
    det_nxt_s      = det_r;
    origin_nxt_s   = origin_r;
    tc_nxt_s       = 1'b0;
    rv_nxt_s       = 1'b0;
    ridx_nxt_s     = ridx_r;
    dl_cnt_nxt_s   = dl_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (|dl_in_vec) begin
          state_nxt_s    = ST_CONFIRM;
          cand_nxt_s     = pick_onehot_s;
          cand_idx_nxt_s = pick_idx_s;
          conf_cnt_nxt_s = 8'd1;
        end else begin
          state_nxt_s    = ST_IDLE;
        end
      end
      ST_CONFIRM: begin
        if ((dl_in_vec & cand_r) == '0) begin
          state_nxt_s    = ST_IDLE;
          cand_nxt_s     = '0;
          cand_idx_nxt_s = '0;
          conf_cnt_nxt_s = 8'd0;
        end else if (conf_cnt_r < CONF_MAX) begin
          conf_cnt_nxt_s = conf_cnt_r + 8'd1;
        end else begin
          state_nxt_s  = ST_LOCKED;
          det_nxt_s    = 1'b1;
          origin_nxt_s = cand_r;
          rv_nxt_s     = 1'b1;
          ridx_nxt_s   = cand_idx_r;
          if (dl_cnt_r == CNT_SAT) begin
            dl_cnt_nxt_s = CNT_SAT;
          end else begin
            dl_cnt_nxt_s = dl_cnt_r + 8'd1;
          end
        end
      end
      ST_LOCKED: begin
        state_nxt_s = ST_CLEAR;
        tc_nxt_s    = 1'b1;
      end
      ST_CLEAR: begin
        state_nxt_s = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Re-arm only once every detect unit has let go.
        if (dl_in_vec == '0) begin
          state_nxt_s    = ST_IDLE;
          det_nxt_s      = 1'b0;
          origin_nxt_s   = '0;
          ridx_nxt_s     = '0;
          cand_nxt_s     = '0;
          cand_idx_nxt_s = '0;
          conf_cnt_nxt_s = 8'd0;
        end else begin
          state_nxt_s    = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        cand_nxt_s     = '0;
        cand_idx_nxt_s = '0;
        conf_cnt_nxt_s = 8'd0;
        det_nxt_s      = 1'b0;
        origin_nxt_s   = '0;
        ridx_nxt_s     = '0;
      end
    endcase
  end

  // State, counter and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      cand_r     <= '0;
      cand_idx_r <= '0;
      conf_cnt_r <= 8'd0;
      det_r      <= 1'b0;
      origin_r   <= '0;
      tc_r       <= 1'b0;
      rv_r       <= 1'b0;
      ridx_r     <= '0;
      dl_cnt_r   <= '0;
    end else begin
      state_r    <= state_nxt_s;
      cand_r     <= cand_nxt_s;
      cand_idx_r <= cand_idx_nxt_s;
      conf_cnt_r <= conf_cnt_nxt_s;
      det_r      <= det_nxt_s;
      origin_r   <= origin_nxt_s;
      tc_r       <= tc_nxt_s;
      rv_r       <= rv_nxt_s;
      ridx_r     <= ridx_nxt_s;
      dl_cnt_r   <= dl_cnt_nxt_s;
    end
  end

  assign dl_detect_out = det_r;
  assign origin        = origin_r;
  assign token_clear   = tc_r;
  assign report_vld    = rv_r;
  assign report_idx    = ridx_r;
  assign dl_count      = dl_cnt_r;

endmodule

// File: tb/tb_deadlock_origin_arbiter.sv
// Directed table-driven bench: a CONFIRM_CYCLES=4 instance for episode timing and
// a CONFIRM_CYCLES=1 instance for dl_count saturation.
module tb_deadlock_origin_arbiter;

  typedef struct packed {
    logic [1:0] din;
    logic       det;
    logic [1:0] org;
    logic       tc;
    logic       rv;
    logic       idx;
    logic [7:0] cnt;
  } vec_t;

  logic       clock;
  logic       reset;
  logic [1:0] din4, din1;
  logic       det4, tc4, rv4, idx4;
  logic [1:0] org4;
  logic [7:0] cnt4;
  logic       det1, tc1, rv1, idx1;
  logic [1:0] org1;
  logic [7:0] cnt1;

  int pass_cnt = 0;
  int total_cnt = 0;
  vec_t tbl[$];

  deadlock_origin_arbiter #(.PROC_NUM(2), .CONFIRM_CYCLES(4)) dut4 (
    .clock(clock), .reset(reset), .dl_in_vec(din4), .dl_detect_out(det4),
    .origin(org4), .token_clear(tc4), .report_vld(rv4), .report_idx(idx4), .dl_count(cnt4)
  );

  deadlock_origin_arbiter #(.PROC_NUM(2), .CONFIRM_CYCLES(1)) dut1 (
    .clock(clock), .reset(reset), .dl_in_vec(din1), .dl_detect_out(det1),
    .origin(org1), .token_clear(tc1), .report_vld(rv1), .report_idx(idx1), .dl_count(cnt1)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic vec_t mk(input logic [1:0] d, input logic de, input logic [1:0] o,
                              input logic t, input logic r, input logic i, input logic [7:0] c);
    vec_t v;
    v.din = d; v.det = de; v.org = o; v.tc = t; v.rv = r; v.idx = i; v.cnt = c;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [7:0] exp_cnt;

    reset = 1'b0;
    din4  = 2'b00;
    din1  = 2'b00;
    tick();
    tick();
    check("reset_dut4", {18'd0, det4, org4, tc4, rv4, idx4, cnt4}, 32'd0);
    check("reset_dut1", {18'd0, det1, org1, tc1, rv1, idx1, cnt1}, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // single requester 01: lock after edge 4, clear pulse after edge 5
    for (int i = 0; i < 4; i++) tbl.push_back(mk(2'b01, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'd0));
    tbl.push_back(mk(2'b01, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 8'd1));
    tbl.push_back(mk(2'b01, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 8'd1));
    tbl.push_back(mk(2'b01, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 8'd1));
    tbl.push_back(mk(2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'd1));
    // short glitch on bit 1: never locks
    for (int i = 0; i < 3; i++) tbl.push_back(mk(2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'd1));
    tbl.push_back(mk(2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'd1));
    // both bits: lowest wins, drain holds until all-zero at rel edge 8
    for (int i = 0; i < 4; i++) tbl.push_back(mk(2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'd1));
    tbl.push_back(mk(2'b11, 1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 8'd2));
    tbl.push_back(mk(2'b11, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 8'd2));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(2'b11, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 8'd2));
    tbl.push_back(mk(2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'd2));
    // candidate 0 drops mid-confirm, bit 1 takes over on the next edge
    tbl.push_back(mk(2'b11, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'd2));
    tbl.push_back(mk(2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'd2));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'd2));
    tbl.push_back(mk(2'b10, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 8'd3));
    tbl.push_back(mk(2'b10, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 8'd3));
    tbl.push_back(mk(2'b00, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 8'd3));
    tbl.push_back(mk(2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 8'd3));

    foreach (tbl[n]) begin
      din4 = tbl[n].din;
      tick();
      check($sformatf("vec%0d", n), {18'd0, det4, org4, tc4, rv4, idx4, cnt4},
            {18'd0, tbl[n].det, tbl[n].org, tbl[n].tc, tbl[n].rv, tbl[n].idx, tbl[n].cnt});
    end

    // drive into DRAIN, then assert reset between edges
    din4 = 2'b01;
    for (int i = 0; i < 7; i++) tick();
    check("drain_before_reset", {23'd0, det4, cnt4}, {23'd0, 1'b1, 8'd4});
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_dut4", {18'd0, det4, org4, tc4, rv4, idx4, cnt4}, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // first edge after release is an IDLE edge: lock lands exactly after edge 4
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("post_reset_e%0d", i), {30'd0, det4, rv4},
            (i == 4) ? 32'd3 : 32'd0);
    end
    din4 = 2'b00;
    for (int i = 0; i < 3; i++) tick();
    check("post_reset_idle", {23'd0, det4, cnt4}, {23'd0, 1'b0, 8'd1});

    // 256 back-to-back episodes on the single-cycle-confirm instance
    exp_cnt = 8'd0;
    for (int ep = 0; ep < 256; ep++) begin
      din1 = 2'b01;
      tick();
      tick();
      if (exp_cnt != 8'd255) exp_cnt = exp_cnt + 8'd1;
      check($sformatf("sat_ep%0d", ep), {23'd0, rv1, cnt1}, {23'd0, 1'b1, exp_cnt});
      din1 = 2'b00;
      for (int i = 0; i < 3; i++) tick();
    end
    check("sat_final", {24'd0, cnt1}, 32'd255);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/deadlock_origin_arbiter.md
DEADLOCK_ORIGIN_ARBITER -- requirements
Module: deadlock_origin_arbiter

Interface
REQ-001 Parameter PROC_NUM, default 2: number of detect units feeding dl_in_vec; legal range 2..64.
REQ-002 Parameter CONFIRM_CYCLES, default 4: consecutive sampling edges a candidate must stay asserted before lock; legal range 1..255.
REQ-003 clock  input  1  single clock for the whole block; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 dl_in_vec  input  PROC_NUM  per-process deadlock-suspect flags from the detect units.
REQ-006 dl_detect_out  output  1  global deadlock-locked indication, broadcast back to all detect units.
REQ-007 origin  output  PROC_NUM  one-hot process elected as deadlock origin; all-zero when not locked.
REQ-008 token_clear  output  1  one-cycle pulse instructing detect units to drop circulating tokens.
REQ-009 report_vld  output  1  one-cycle pulse marking a new confirmed deadlock.
REQ-010 report_idx  output  max(1,clog2(PROC_NUM))  binary index of origin, valid while report_vld is 1.
REQ-011 dl_count  output  8  saturating count of confirmed deadlocks since reset.

Function
REQ-012 All outputs SHALL be driven from registers; no combinational path from dl_in_vec to any output.
REQ-013 FSM states SHALL be IDLE, CONFIRM, LOCKED, CLEAR, DRAIN.
REQ-014 IDLE: on an edge sampling dl_in_vec != 0, latch candidate = lowest-index set bit (one-hot), set confirm counter to 1, go to CONFIRM.
REQ-015 CONFIRM: on an edge sampling the candidate bit 0, clear counter and candidate, go to IDLE; no outputs change.
REQ-016 CONFIRM: on an edge sampling the candidate bit 1 with counter < CONFIRM_CYCLES, increment counter; other bits of dl_in_vec are ignored.
REQ-017 CONFIRM: on an edge sampling the candidate bit 1 with counter == CONFIRM_CYCLES, go to LOCKED; dl_detect_out=1, origin=candidate, report_vld=1, report_idx=index of candidate, dl_count incremented.
REQ-018 Latency: with candidate high from sampling edge k, dl_detect_out SHALL be observed high after edge k+CONFIRM_CYCLES.
REQ-019 LOCKED lasts exactly one cycle, then CLEAR; report_vld returns to 0 on leaving LOCKED.
REQ-020 CLEAR lasts exactly one cycle with token_clear=1, then DRAIN; token_clear SHALL never be high in any other state.
REQ-021 DRAIN: dl_detect_out and origin held; on an edge sampling dl_in_vec == 0, go to IDLE with dl_detect_out=0 and origin=0.
REQ-022 dl_count SHALL saturate at 255 and never wrap.
REQ-023 Multiple bits rising on the same edge: lowest index wins; higher bits are never reported for that episode.
REQ-024 A new episode SHALL NOT begin until DRAIN has observed dl_in_vec all-zero.

Reset
REQ-025 Reset assertion SHALL, asynchronously and in any state, force IDLE, counter 0, candidate 0, and all outputs 0 including dl_count.
REQ-026 After deassertion the first sampling edge SHALL be treated as an IDLE edge per REQ-014.

Structure
REQ-027 The shared package SHALL hold the state enumeration, the index-width function max(1,clog2(n)), and the dl_count width constant (8).
REQ-028 One sub-module, dl_prio_onehot, SHALL compute lowest-set-bit one-hot and binary index from a PROC_NUM vector; the FSM, counter and output registers stay in the top module.

Verification
REQ-029 PROC_NUM=2, CONFIRM_CYCLES=4, dl_in_vec=2'b01 from edge 0 -> dl_detect_out=1, origin=01, report_vld=1, report_idx=0 after edge 4; token_clear=1 only after edge 5; dl_count=1.
REQ-030 dl_in_vec=2'b10 for edges 0..2 then 2'b00 -> no output ever asserts; FSM back in IDLE after edge 3.
REQ-031 dl_in_vec=2'b11 from edge 0 -> origin=01, report_idx=0; clear to 2'b00 at edge 8 -> dl_detect_out=0 and origin=00 after edge 8.
REQ-032 Reset asserted in DRAIN -> all outputs 0 immediately (before next edge), dl_count=0.
REQ-033 CONFIRM_CYCLES=1, 256 full episodes back-to-back -> dl_count stays 255 after 255th; report_vld still pulses each episode.
REQ-034 Candidate bit 0 dropped in CONFIRM while bit 1 high -> return to IDLE, then a new episode for bit 1 starts on the next edge with report_idx=1 on lock.
